pattern_stream_generator: RTL

PATTERN_STREAM_GENERATOR -- requirements
Module: pattern_stream_generator

---
 rtl/pattern_stream_generator.sv | 130 +++++++++++++
 1 files changed

// File: rtl/pattern_stream_generator.sv
// Serial pattern burst generator: repeats a latched pattern MSB first with idle gaps.
// Optional PSG_LFSR_FILL_EN: fill gap cycles with a 7-bit LFSR bit stream.
module pattern_stream_generator #(
   parameter int PAT_W   = 4,
   parameter int GAP_LEN = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [PAT_W-1:0] pat_in,
   input  logic [3:0]       rep_in,
   output logic             seq,
   output logic             seq_valid,
   output logic             frame_start,
   output logic             busy,
   output logic             done
);

   localparam int BW = $clog2(PAT_W);
   localparam int GW = (GAP_LEN > 1) ? $clog2(GAP_LEN) : 1;

   typedef enum logic [1:0] {IDLE, SEND, GAP, FIN} state_t;

   state_t           state, state_nxt;
   logic [PAT_W-1:0] pat_q, sh_q;
   logic [3:0]       rep_q;
   logic [BW-1:0]    bit_q;
   logic [GW-1:0]    gap_q;
   logic             last_bit, last_gap, more;

   assign last_bit = (bit_q == BW'(PAT_W - 1));
   assign last_gap = (gap_q == GW'(GAP_LEN - 1));
   assign more     = (rep_q != 4'd1);

`ifdef PSG_LFSR_FILL_EN
   logic [6:0] lfsr_q;

   // x^7 + x^6 + 1, stepped only while filling a gap
   always_ff @(posedge clk) begin
      if (reset)
         lfsr_q <= 7'h5A;
      else if (state == GAP)
         lfsr_q <= {lfsr_q[5:0], lfsr_q[6] ^ lfsr_q[5]};
   end
`endif

   always_ff @(posedge clk) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt   = state;
      seq         = 1'b0;
      seq_valid   = 1'b0;
      frame_start = 1'b0;
      busy        = 1'b1;
      done        = 1'b0;
      unique case (state)
         IDLE: begin
            busy = 1'b0;
            if (start)
               state_nxt = (rep_in == 4'd0) ? FIN : SEND;
         end
         SEND: begin
            seq         = sh_q[PAT_W-1];
            seq_valid   = 1'b1;
            frame_start = (bit_q == '0);
            if (last_bit) begin
               if (!more)
                  state_nxt = FIN;
               else if (GAP_LEN > 0)
                  state_nxt = GAP;
               else
                  state_nxt = SEND;
            end
         end
         GAP: begin
`ifdef PSG_LFSR_FILL_EN
            seq       = lfsr_q[6];
            seq_valid = 1'b1;
`endif
            if (last_gap)
               state_nxt = SEND;
         end
         FIN: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pat_q <= '0;
         sh_q  <= '0;
         rep_q <= '0;
         bit_q <= '0;
         gap_q <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (start) begin
                  pat_q <= pat_in;
                  sh_q  <= pat_in;
                  rep_q <= rep_in;
                  bit_q <= '0;
                  gap_q <= '0;
               end
            end
            SEND: begin
               if (last_bit) begin
                  bit_q <= '0;
                  rep_q <= rep_q - 4'd1;
                  sh_q  <= pat_q;
               end else begin
                  bit_q <= bit_q + BW'(1);
                  sh_q  <= {sh_q[PAT_W-2:0], 1'b0};
               end
            end
            GAP: gap_q <= last_gap ? '0 : gap_q + GW'(1);
            default: ;
         endcase
      end
   end

endmodule
